serial_subtractor_ctrl: RTL
===========================

# serial_subtractor_ctrl

Bit-serial N-bit subtractor: one `full_subtractor` cell is time-multiplexed over all bit positions, LSB first. This block holds the inter-bit borrow in a flop and owns the operand and result shift registers. It runs the start/busy/done handshake under a small FSM. It is the area-minimal subtract unit for the datapath: one gate-level cell plus WIDTH-scale registers, instead of a WIDTH-cell ripple chain.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, input, 1, rising-edge clock.
  - rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a new subtraction; sampled only in IDLE.
- a, input, WIDTH, minuend; captured on the accepting edge only.
- b, input, WIDTH, subtrahend; captured on the accepting edge only.
- bin, input, 1, initial borrow into bit 0; captured with a and b.
- busy, output, 1, high from the accepting edge until the return to IDLE.
- done, output, 1, one-cycle pulse when the results are valid.
- diff, output, WIDTH, a − b − bin modulo 2^WIDTH; holds until the next done.
- bout, output, 1, borrow out of the MSB (unsigned a < b + bin); holds until the next done.
- zero, output, 1, diff == 0; holds until the next done.

## Operation

- Datapath: exactly one `full_subtractor` instance.
  - Inputs a_sh[0], b_sh[0], brw.
  - Outputs d_bit, b_nxt.
- FSM states are IDLE, RUN and DONE. The encoding is free; illegal states recover to IDLE.
- IDLE:
  - busy=0, done=0.
  - On start=1: a_sh←a, b_sh←b, brw←bin, cnt←0, go to RUN.
- RUN, each edge:
  - a_sh and b_sh shift right by 1.
  - d_sh←{d_bit, d_sh[WIDTH-1:1]}.
  - brw←b_nxt.
  - cnt←cnt+1.
  - When cnt==WIDTH-1, that edge processes the MSB and goes to DONE. On the same edge: diff←final d_sh value, bout←b_nxt, zero←(final d_sh==0).
- DONE:
  - done=1, busy=1.
  - The next edge goes to IDLE unconditionally; start is ignored.
- start while busy is ignored, with no queuing. Changes to a, b or bin after acceptance have no effect.
- Width rules:
  - cnt is $clog2(WIDTH) bits and never wraps mid-operation.
  - diff is two's-complement wraparound; bout=1 exactly when a < b+bin (unsigned).
- Reset (any time, including mid-RUN):
  - Aborts immediately; state=IDLE.
  - busy=0, done=0, diff=0, bout=0, zero=0.
  - All shift registers, brw and cnt cleared.
  - No done is produced for the aborted operation.
- diff, bout and zero are registered and change only on the edge that enters DONE.

## Timing

- E0 = the edge that samples start=1 in IDLE.
- After E0: busy=1.
- Edges E1..EWIDTH process bits 0..WIDTH-1.
- After EWIDTH: done=1; diff, bout and zero are valid.
- After EWIDTH+1: done=0, busy=0, state IDLE.
- Latency is WIDTH edges from E0 to done. busy is high for WIDTH+1 cycles.
- With start held high continuously, the next operation is accepted at EWIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- done is never high for two consecutive cycles.
- No combinational path from any input to any output.

## Test plan

- WIDTH=8; a=0x5A, b=0x23, bin=0, start pulse at E0 → done high only after E8; diff=0x37, bout=0, zero=0; busy high for 9 cycles.
- a=0x10, b=0x20, bin=0 → diff=0xF0, bout=1, zero=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- a=b=0x7C, bin=0 → diff=0x00, zero=1, bout=0. Results remain stable through the following idle cycles until the next done.
- Operation accepted with a=0x5A, b=0x23. While busy, pulse start and change a, b to 0xFF/0x01 → exactly one done, diff=0x37. With start held high throughout, a second acceptance occurs at E10.
- Assert rst_n=0 asynchronously mid-cycle during RUN (after E4):
  - Required at the reset: busy=0, done=0, diff=0, bout=0, zero=0 immediately; no done appears afterwards.
  - After release: a=0x01, b=0x02 → diff=0xFF, bout=1.
- 1000 random (a, b, bin) triples against a − b − bin: diff and bout match, done appears once per operation. Repeat at WIDTH=2 and WIDTH=32.

Source files
------------

// File: rtl/serial_subtractor_ctrl_if.sv
//==============================================================================
// Module   : serial_subtractor_ctrl_if
// Brief    : Start/busy/done request bus and result bus of the bit-serial subtractor.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor_ctrl.sv
//==============================================================================
// Module   : serial_subtractor_ctrl
// Brief    : Bit-serial WIDTH-bit subtractor, LSB first, using one full_subtractor cell.
// Revision : 1.0
//==============================================================================
`default_nettype none

module full_subtractor (
  input  wire logic a,
  input  wire logic b,
  input  wire logic bin,
  output logic      d,
  output logic      bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input wire logic          clk,
  input wire logic          rst_n,
  serial_subtractor_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             zero_r;

  logic             d_bit;
  logic             b_nxt;
  logic [WIDTH-1:0] d_next;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (b_nxt)
  );

  // The result register fills from the top, so after WIDTH shifts bit 0 lands at index 0.
  assign d_next = {d_bit, d_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            brw   <= bus.bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          d_sh <= d_next;
          brw  <= b_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            diff_r <= d_next;
            bout_r <= b_nxt;
            zero_r <= (d_next == '0);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN) || (state == DONE);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.zero = zero_r;
endmodule

`default_nettype wire
